erm16_mem_io_responder: RTL and testbench



---
 rtl/erm16_bus_pkg.sv | 35 +++
 rtl/erm16_mem_io_responder_ram.sv | 23 ++
 rtl/erm16_mem_io_responder.sv | 111 +++++++++++
 tb/tb_erm16_mem_io_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/erm16_bus_pkg.sv
// ERM16 bus responder shared definitions.
// I/O register map and decoded select type.
package erm16_bus_pkg;

  localparam logic [2:0] IO_IN      = 3'd0;
  localparam logic [2:0] IO_OUT     = 3'd1;
  localparam logic [2:0] IO_STATUS  = 3'd2;
  localparam logic [2:0] IO_IRQ_CNT = 3'd3;
  localparam logic [2:0] IO_SCRATCH = 3'd4;

  localparam int ST_IRQ = 0;

  typedef enum logic [2:0] {
    SEL_IN,
    SEL_OUT,
    SEL_STATUS,
    SEL_CNT,
    SEL_SCRATCH,
    SEL_NONE
  } io_sel_t;

  function automatic io_sel_t io_decode(input logic [2:0] a);
    io_sel_t s;
    case (a)
      IO_IN:      s = SEL_IN;
      IO_OUT:     s = SEL_OUT;
      IO_STATUS:  s = SEL_STATUS;
      IO_IRQ_CNT: s = SEL_CNT;
      IO_SCRATCH: s = SEL_SCRATCH;
      default:    s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/erm16_mem_io_responder_ram.sv
// Single-port-pair 16-bit RAM, synchronous read-before-write.
// Contents are never reset.
module ram_1rw16 #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   q
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    q <= mem[raddr];
  end

endmodule

// File: rtl/erm16_mem_io_responder.sv
// ERM16 bus responder: RAM, I/O registers and interrupt latch.
// rdata is a mux of registered sources, one-cycle read latency.
module erm16_mem_io_responder
  import erm16_bus_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   addr,
  input  logic [15:0]   wdata,
  input  logic          wrmem,
  input  logic          ioe,
  input  logic          intreq,
  output logic [15:0]   rdata,
  input  logic [15:0]   io_in,
  output logic [15:0]   io_out,
  output logic          io_out_stb,
  output logic          irq_pending,
  input  logic          irq_ack,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [15:0]   ld_data
);

  logic [31:0]   addr_hi;
  logic          in_range;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_q;
  logic          rd_ram;
  logic [15:0]   io_q;
  logic [15:0]   io_rd;
  logic [15:0]   irq_cnt;
  logic [15:0]   scratch;
  logic          intreq_q;
  logic          irq_edge;
  logic          io_wr;
  logic          st_clr;
  io_sel_t       sel;

  assign addr_hi  = 32'(addr) >> AW;
  assign in_range = (addr_hi == 32'd0);
  assign sel      = io_decode(addr[2:0]);
  assign io_wr    = wrmem && ioe;
  assign st_clr   = io_wr && (sel == SEL_STATUS) && wdata[ST_IRQ];

  // Preload owns the write port; bus writes die under reset
  assign ram_we    = ld_en || (wrmem && !ioe && in_range && !rst);
  assign ram_waddr = ld_en ? ld_addr : addr[AW-1:0];
  assign ram_wdata = ld_en ? ld_data : wdata;

  ram_1rw16 #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(addr[AW-1:0]),
    .q    (ram_q)
  );

  always_comb begin
    io_rd = '0;
    case (sel)
      SEL_IN:      io_rd = io_in;
      SEL_OUT:     io_rd = io_out;
      SEL_STATUS:  io_rd = {15'b0, irq_pending};
      SEL_CNT:     io_rd = irq_cnt;
      SEL_SCRATCH: io_rd = scratch;
      default:     io_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ram      <= 1'b0;
      io_q        <= '0;
      io_out      <= '0;
      io_out_stb  <= 1'b0;
      irq_pending <= 1'b0;
      irq_cnt     <= '0;
      scratch     <= '0;
      intreq_q    <= 1'b0;
      irq_edge    <= 1'b0;
    end else begin
      intreq_q <= intreq;
      irq_edge <= intreq && !intreq_q;
      if (irq_edge && irq_cnt != 16'hFFFF)
        irq_cnt <= irq_cnt + 16'd1;
      if (irq_edge)
        irq_pending <= 1'b1;
      else if (irq_ack || st_clr)
        irq_pending <= 1'b0;
      io_out_stb <= io_wr && (sel == SEL_OUT);
      if (io_wr && sel == SEL_OUT)
        io_out <= wdata;
      if (io_wr && sel == SEL_SCRATCH)
        scratch <= wdata;
      rd_ram <= !ioe && in_range;
      io_q   <= ioe ? io_rd : 16'h0000;
    end
  end

  assign rdata = rd_ram ? ram_q : io_q;

endmodule

// File: tb/tb_erm16_mem_io_responder.sv
// Directed bench for erm16_mem_io_responder.
// Inputs change 1ns after a rising edge; outputs checked there too.
module tb_erm16_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        wrmem;
  logic        ioe;
  logic        intreq;
  logic [15:0] rdata;
  logic [15:0] io_in;
  logic [15:0] io_out;
  logic        io_out_stb;
  logic        irq_pending;
  logic        irq_ack;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  erm16_mem_io_responder #(.DEPTH(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .wdata      (wdata),
    .wrmem      (wrmem),
    .ioe        (ioe),
    .intreq     (intreq),
    .rdata      (rdata),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_out_stb (io_out_stb),
    .irq_pending(irq_pending),
    .irq_ack    (irq_ack),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wrmem   = 1'b0;
    ld_en   = 1'b0;
    irq_ack = 1'b0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic io,
                    input string tag, input logic [15:0] exp);
    idle();
    addr = a; ioe = io;
    step();
    check(tag, rdata, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic io,
                    input logic [15:0] d);
    addr = a; ioe = io; wdata = d; wrmem = 1'b1;
    step();
    wrmem = 1'b0;
  endtask

  task automatic pulse();
    intreq = 1'b1;
    step();
    intreq = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; wrmem = 1'b0; ioe = 1'b0;
    intreq = 1'b0; io_in = '0; irq_ack = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    step();
    step();
    check("rst_rdata", rdata, 16'h0000);
    check("rst_io_out", io_out, 16'h0000);
    check("rst_stb", {15'b0, io_out_stb}, 16'h0000);
    check("rst_pend", {15'b0, irq_pending}, 16'h0000);
    rst = 1'b0;

    preload(8'd3, 16'hA5A5);
    preload(8'd0, 16'h1234);
    preload(8'd7, 16'h0707);
    rd(16'd3, 1'b0, "ram_rd3", 16'hA5A5);

    wr(16'h0100, 1'b0, 16'hBEEF);
    rd(16'h0100, 1'b0, "oor_rd", 16'h0000);
    rd(16'h0000, 1'b0, "idx0_kept", 16'h1234);

    wr(16'd1, 1'b1, 16'h0042);
    check("io_out_wr", io_out, 16'h0042);
    check("stb_hi", {15'b0, io_out_stb}, 16'h0001);
    rd(16'd1, 1'b1, "io_out_rd", 16'h0042);
    check("stb_lo", {15'b0, io_out_stb}, 16'h0000);

    addr = 16'd1; ioe = 1'b1; wrmem = 1'b1; wdata = 16'h0001;
    step();
    wdata = 16'h0002;
    step();
    check("stb_b2b", {15'b0, io_out_stb}, 16'h0001);
    check("io_out_b2b", io_out, 16'h0002);
    idle();
    step();
    check("stb_b2b_end", {15'b0, io_out_stb}, 16'h0000);

    wr(16'd4, 1'b1, 16'hCAFE);
    rd(16'd4, 1'b1, "scratch", 16'hCAFE);
    rd(16'd12, 1'b1, "scratch_alias", 16'hCAFE);
    rd(16'd6, 1'b1, "io_unmapped", 16'h0000);
    io_in = 16'h5A5A;
    rd(16'd0, 1'b1, "io_in", 16'h5A5A);

    pulse();
    pulse();
    pulse();
    rd(16'd3, 1'b1, "irq_cnt3", 16'h0003);
    check("pend_set", {15'b0, irq_pending}, 16'h0001);

    intreq = 1'b1;
    step();
    intreq = 1'b0; irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("set_wins", {15'b0, irq_pending}, 16'h0001);
    rd(16'd3, 1'b1, "irq_cnt4", 16'h0004);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("ack_clr", {15'b0, irq_pending}, 16'h0000);

    pulse();
    wr(16'd2, 1'b1, 16'h0000);
    check("st_wr0", {15'b0, irq_pending}, 16'h0001);
    rd(16'd2, 1'b1, "status_rd", 16'h0001);
    wr(16'd2, 1'b1, 16'h0001);
    check("st_wr1", {15'b0, irq_pending}, 16'h0000);

    ld_en = 1'b1; ld_addr = 8'd5; ld_data = 16'h1111;
    wr(16'd5, 1'b0, 16'h2222);
    ld_en = 1'b0;
    rd(16'd5, 1'b0, "ld_wins", 16'h1111);

    pulse();
    wr(16'd7, 1'b0, 16'h7777);
    rd(16'd7, 1'b0, "ram_wr7", 16'h7777);
    addr = 16'd7; ioe = 1'b0; wdata = 16'h9999; wrmem = 1'b1;
    rst = 1'b1;
    step();
    check("mid_rdata", rdata, 16'h0000);
    check("mid_io_out", io_out, 16'h0000);
    check("mid_stb", {15'b0, io_out_stb}, 16'h0000);
    check("mid_pend", {15'b0, irq_pending}, 16'h0000);
    rst = 1'b0;
    rd(16'd7, 1'b0, "wr_dropped", 16'h7777);
    rd(16'd3, 1'b0, "ram_intact", 16'hA5A5);
    rd(16'd3, 1'b1, "cnt_rst", 16'h0000);
    rd(16'd4, 1'b1, "scratch_rst", 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
